// File: rtl/ising_energy_engine.sv
// ising_energy_engine
//   Streams the coupling matrix J in column chunks and accumulates the Ising
//   energy E = sum_k sum_col s(k) * J[k][col] * s(col), with s(k) = +1 when
//   sigma bit k is set and -1 otherwise.
//
//   Optional feature macro: ISING_EARLY_ABORT_EN
//     When defined, the run stops early once the running sum after a non-final
//     chunk reaches the latched energy_prev threshold; the partial sum is
//     reported and aborted is set. When undefined, no compare logic is built
//     and aborted stays 0.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        begin a computation (IDLE only, ignored while clear=1)
//   clear        abandon a running computation (RUN/DONE)
//   sigma        spin vector, latched on accepted start
//   energy_prev  signed early-abort threshold, latched on accepted start
//   j_valid      j_chunk carries valid data
//   j_ready      chunk accepted this cycle when j_valid is also high
//   j_chunk      element (row k, col c) at bit (k*J_COLS_PER_CLK+c)*J_ELEMENT_WIDTH
//   busy         high in RUN and DONE
//   done         one-cycle completion pulse
//   aborted      last completion was an early abort
//   energy_out   signed result of the last completion
//   chunk_idx    index of the next chunk expected
module ising_energy_engine #(
    parameter int VECTOR_SIZE     = 256,
    parameter int J_ELEMENT_WIDTH = 4,
    parameter int J_COLS_PER_CLK  = 4,
    localparam int NUM_CHUNKS     = VECTOR_SIZE / J_COLS_PER_CLK,
    localparam int ENERGY_WIDTH   = 2 * $clog2(VECTOR_SIZE) + J_ELEMENT_WIDTH + 1,
    localparam int IDX_W          = $clog2(NUM_CHUNKS)
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 start,
    input  logic                                                 clear,
    input  logic [VECTOR_SIZE-1:0]                               sigma,
    input  logic [ENERGY_WIDTH-1:0]                              energy_prev,
    input  logic                                                 j_valid,
    output logic                                                 j_ready,
    input  logic [VECTOR_SIZE*J_COLS_PER_CLK*J_ELEMENT_WIDTH-1:0] j_chunk,
    output logic                                                 busy,
    output logic                                                 done,
    output logic                                                 aborted,
    output logic [ENERGY_WIDTH-1:0]                              energy_out,
    output logic [IDX_W-1:0]                                     chunk_idx
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam int EW = ENERGY_WIDTH;
    localparam int JW = J_ELEMENT_WIDTH;

    logic [1:0]             state;
    logic [VECTOR_SIZE-1:0] sigma_q;
    logic signed [EW-1:0]   acc;
    logic                   abort_q;

    logic                   accept;
    logic                   last_chunk;
    logic [VECTOR_SIZE-1:0] col_spins;
    logic [JW-1:0]          elem;
    logic signed [EW-1:0]   elem_x;
    logic signed [EW-1:0]   col_sum;
    logic signed [EW-1:0]   partial;
    logic signed [EW-1:0]   acc_next;

    assign j_ready    = (state == RUN);
    assign busy       = (state != IDLE);
    assign accept     = j_valid && j_ready;
    assign last_chunk = (chunk_idx == IDX_W'(NUM_CHUNKS - 1));

    // Spins of this chunk's columns land in the low J_COLS_PER_CLK bits.
    assign col_spins = sigma_q >> (int'(chunk_idx) * J_COLS_PER_CLK);

    // Per column: col_sum = sum_k s(k)*J[k][c]; then weight by the column spin.
    // Multiplying by +/-1 reduces to add or subtract.
    always_comb begin
        partial = '0;
        col_sum = '0;
        elem    = '0;
        elem_x  = '0;
        for (int c = 0; c < J_COLS_PER_CLK; c++) begin
            col_sum = '0;
            for (int k = 0; k < VECTOR_SIZE; k++) begin
                elem    = j_chunk[(k*J_COLS_PER_CLK + c)*JW +: JW];
                elem_x  = {{(EW-JW){elem[JW-1]}}, elem};
                col_sum = sigma_q[k] ? (col_sum + elem_x) : (col_sum - elem_x);
            end
            partial = col_spins[c] ? (partial + col_sum) : (partial - col_sum);
        end
    end

    assign acc_next = acc + partial;

`ifdef ISING_EARLY_ABORT_EN
    logic signed [EW-1:0] eprev_q;
    logic                 hit_threshold;

    assign hit_threshold = (acc_next >= eprev_q);

    always_ff @(posedge clk) begin
        if (rst)
            eprev_q <= '0;
        else if (state == IDLE && start && !clear)
            eprev_q <= energy_prev;
    end
`else
    logic unused_eprev;
    logic hit_threshold;

    assign unused_eprev  = ^energy_prev;
    assign hit_threshold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sigma_q    <= '0;
            acc        <= '0;
            abort_q    <= 1'b0;
            chunk_idx  <= '0;
            energy_out <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !clear) begin
                        sigma_q   <= sigma;
                        acc       <= '0;
                        abort_q   <= 1'b0;
                        chunk_idx <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // clear wins over a chunk presented in the same cycle
                    if (clear) begin
                        state <= IDLE;
                    end else if (accept) begin
                        acc       <= acc_next;
                        chunk_idx <= chunk_idx + IDX_W'(1);
                        if (last_chunk) begin
                            state <= DONE;
                        end else if (hit_threshold) begin
                            abort_q   <= 1'b1;
                            chunk_idx <= '0;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Results are published on the way out of DONE so that a
                    // clear arriving in DONE can still suppress them.
                    state <= IDLE;
                    if (!clear) begin
                        done       <= 1'b1;
                        energy_out <= acc;
                        aborted    <= abort_q;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ising_energy_engine.sv
module tb_ising_energy_engine;
    localparam int VS  = 8;
    localparam int JW  = 4;
    localparam int CPC = 2;
    localparam int NC  = VS / CPC;
    localparam int EW  = 2 * $clog2(VS) + JW + 1;

    logic                   clk = 1'b0;
    logic                   rst, start, clear, j_valid;
    logic [VS-1:0]          sigma;
    logic [EW-1:0]          energy_prev;
    logic [VS*CPC*JW-1:0]   j_chunk;
    logic                   j_ready, busy, done, aborted;
    logic [EW-1:0]          energy_out;
    logic [$clog2(NC)-1:0]  chunk_idx;

    int errors = 0;
    int checks = 0;
    int jm [VS][VS];

    ising_energy_engine #(
        .VECTOR_SIZE(VS), .J_ELEMENT_WIDTH(JW), .J_COLS_PER_CLK(CPC)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear), .sigma(sigma),
        .energy_prev(energy_prev), .j_valid(j_valid), .j_ready(j_ready),
        .j_chunk(j_chunk), .busy(busy), .done(done), .aborted(aborted),
        .energy_out(energy_out), .chunk_idx(chunk_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // mode 0: all +1, 1: all -1, 2: random in [-8,7]
    task automatic fill_j(input int mode);
        for (int k = 0; k < VS; k++)
            for (int j = 0; j < VS; j++)
                jm[k][j] = (mode == 0) ? 1 : (mode == 1) ? -1 : int'($urandom_range(0, 15)) - 8;
    endtask

    function automatic logic [VS*CPC*JW-1:0] pack(input int ch);
        logic [VS*CPC*JW-1:0] v;
        logic [JW-1:0] e;
        v = '0;
        for (int k = 0; k < VS; k++)
            for (int c = 0; c < CPC; c++) begin
                e = JW'(jm[k][ch*CPC + c]);
                v[(k*CPC + c)*JW +: JW] = e;
            end
        return v;
    endfunction

    // Energy as the plain double sum, walked chunk by chunk for the abort rule.
    task automatic model(input logic [VS-1:0] sg, input int ep,
                         output int e, output int ab, output int n);
        int sk, sc;
        e = 0; ab = 0; n = NC;
        for (int ch = 0; ch < NC; ch++) begin
            for (int c = 0; c < CPC; c++) begin
                sc = sg[ch*CPC + c] ? 1 : -1;
                for (int k = 0; k < VS; k++) begin
                    sk = sg[k] ? 1 : -1;
                    e += sk * jm[k][ch*CPC + c] * sc;
                end
            end
`ifdef ISING_EARLY_ABORT_EN
            if (ch < NC - 1 && e >= ep) begin
                ab = 1; n = ch + 1;
                return;
            end
`endif
        end
    endtask

    task automatic do_reset();
        rst = 1; start = 0; clear = 0; j_valid = 0;
        sigma = '0; energy_prev = '0; j_chunk = '0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_aborted"}, int'(aborted), 0);
        chk({tag, "_energy"}, int'(energy_out), 0);
        chk({tag, "_ready"}, int'(j_ready), 0);
        chk({tag, "_idx"}, int'(chunk_idx), 0);
    endtask

    // Runs one computation; entered and left at posedge+1.
    // vmode 0: j_valid held, 1: every other cycle, 2: random.
    task automatic run(input logic [VS-1:0] sg, input int ep, input int vmode,
                       input bit hold_start, output int e_obs, output int ab_obs,
                       output int lat, output int nacc);
        int cnt;
        bit got, acc;
        cnt = 0; got = 0;
        sigma = sg; energy_prev = EW'(ep); start = 1; j_valid = 0;
        @(posedge clk); #1;
        lat = 1;
        if (!hold_start) start = 0;
        sigma = ~sg;  // must not affect the latched spins
        for (int i = 0; i < 200 && !got; i++) begin
            if (done) begin
                got = 1;
            end else begin
                if (j_ready) chk("chunk_idx", int'(chunk_idx), cnt % NC);
                case (vmode)
                    0:       j_valid = 1'b1;
                    1:       j_valid = (i % 2 == 0);
                    default: j_valid = 1'($urandom_range(0, 1));
                endcase
                j_chunk = pack(cnt % NC);
                acc = j_valid && j_ready;
                @(posedge clk);
                if (acc) cnt++;
                #1 lat++;
            end
        end
        start = 0; j_valid = 0;
        chk("done_seen", int'(got), 1);
        chk("busy_at_done", int'(busy), 0);
        e_obs  = int'($signed(energy_out));
        ab_obs = int'(aborted);
        nacc   = cnt;
    endtask

    task automatic check_run(input string tag, input logic [VS-1:0] sg, input int ep,
                             input int vmode, input bit hold_start);
        int ee, ea, en, oe, oa, lat, na;
        model(sg, ep, ee, ea, en);
        run(sg, ep, vmode, hold_start, oe, oa, lat, na);
        chk({tag, "_energy"}, oe, ee);
        chk({tag, "_aborted"}, oa, ea);
        chk({tag, "_accepts"}, na, en);
    endtask

    initial begin
        int oe, oa, lat, na, dn;
        logic [VS-1:0] sg;
        int ep;

        do_reset();
        check_zero_outputs("reset");

        // all +1 couplings, all spins up, j_valid held: 64 after 6 cycles
        fill_j(0);
        run(8'hFF, 1000, 0, 0, oe, oa, lat, na);
        chk("plus_energy", oe, 64);
        chk("plus_aborted", oa, 0);
        chk("plus_latency", lat, 6);
        chk("plus_accepts", na, 4);
        chk("plus_idx_wrap", int'(chunk_idx), 0);

        fill_j(1);
        run(8'hFF, 1000, 0, 0, oe, oa, lat, na);
        chk("minus_energy", oe, -64);

        fill_j(0);
        run(8'h0F, 1000, 0, 0, oe, oa, lat, na);
        chk("half_energy", oe, 0);

        // stalled stream
        run(8'hFF, 1000, 1, 0, oe, oa, lat, na);
        chk("toggle_energy", oe, 64);
        chk("toggle_accepts", na, 4);
        chk("toggle_idx_wrap", int'(chunk_idx), 0);

        // low threshold
        run(8'hFF, 10, 0, 0, oe, oa, lat, na);
`ifdef ISING_EARLY_ABORT_EN
        chk("abort_energy", oe, 16);
        chk("abort_flag", oa, 1);
        chk("abort_accepts", na, 1);
`else
        chk("abort_energy", oe, 64);
        chk("abort_flag", oa, 0);
        chk("abort_accepts", na, 4);
`endif

        // start held through RUN/DONE must not disturb the result
        fill_j(0);
        run(8'hFF, 1000, 0, 1, oe, oa, lat, na);
        chk("hold_start_energy", oe, 64);
        chk("hold_start_latency", lat, 6);
        @(posedge clk); #1;
        chk("hold_start_no_restart", int'(busy), 0);

        // start with clear in IDLE is ignored
        start = 1; clear = 1; sigma = 8'hFF;
        @(posedge clk); #1;
        start = 0; clear = 0;
        chk("idle_clear_busy", int'(busy), 0);

        // clear after two accepts: no done, energy_out keeps 64
        fill_j(1);
        sigma = 8'hFF; energy_prev = EW'(1000); start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int c = 0; c < 2; c++) begin
            j_valid = 1; j_chunk = pack(c);
            @(posedge clk); #1;
        end
        clear = 1; j_chunk = pack(2);
        @(posedge clk); #1;
        clear = 0; j_valid = 0;
        chk("clear_busy", int'(busy), 0);
        dn = 0;
        repeat (8) begin
            if (done) dn++;
            @(posedge clk); #1;
        end
        chk("clear_no_done", dn, 0);
        chk("clear_keeps_energy", int'($signed(energy_out)), 64);
        check_run("after_clear", 8'hFF, 1000, 0, 0);

        // reset mid-RUN wipes everything, no done afterwards
        fill_j(0);
        sigma = 8'hFF; energy_prev = EW'(1000); start = 1;
        @(posedge clk); #1;
        for (int c = 0; c < 2; c++) begin
            j_valid = 1; j_chunk = pack(c);
            @(posedge clk); #1;
        end
        rst = 1;
        @(posedge clk); #1;
        rst = 0; start = 0; j_valid = 0;
        check_zero_outputs("midrun_rst");
        dn = 0;
        repeat (6) begin
            if (done) dn++;
            @(posedge clk); #1;
        end
        chk("midrun_rst_no_done", dn, 0);

        // randomized couplings, spins, thresholds and stalls
        for (int t = 0; t < 8; t++) begin
            fill_j(2);
            sg = VS'($urandom);
            ep = int'($urandom_range(0, 400)) - 200;
            check_run("random", sg, ep, 2, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ising_energy_engine.md
ISING_ENERGY_ENGINE -- requirements
Module: ising_energy_engine

Interface
REQ-001 SHALL have parameter VECTOR_SIZE, default 256, meaning number of spins in sigma (power of two, >=4).
REQ-002 SHALL have parameter J_ELEMENT_WIDTH, default 4, meaning bit width of each signed two's-complement J element.
REQ-003 SHALL have parameter J_COLS_PER_CLK, default 4, meaning J columns consumed per accepted chunk (power of two, divides VECTOR_SIZE).
REQ-004 SHALL have derived parameter NUM_CHUNKS = VECTOR_SIZE/J_COLS_PER_CLK and ENERGY_WIDTH = 2*$clog2(VECTOR_SIZE)+J_ELEMENT_WIDTH+1.
REQ-005 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  begin a computation (honoured only in IDLE).
REQ-008 SHALL have port clear  input  1  synchronous abandon of a running computation.
REQ-009 SHALL have port sigma  input  VECTOR_SIZE  spin bits, bit k=1 -> +1, 0 -> -1; sampled on accepted start.
REQ-010 SHALL have port energy_prev  input  ENERGY_WIDTH  signed early-abort threshold; sampled on accepted start.
REQ-011 SHALL have port j_valid  input  1  j_chunk holds valid data.
REQ-012 SHALL have port j_ready  output  1  block accepts a chunk this cycle.
REQ-013 SHALL have port j_chunk  input  VECTOR_SIZE*J_COLS_PER_CLK*J_ELEMENT_WIDTH  element (row k, col c) at bit offset (k*J_COLS_PER_CLK+c)*J_ELEMENT_WIDTH.
REQ-014 SHALL have port busy, done, aborted  output  1 each  running / one-cycle completion pulse / completion was early abort.
REQ-015 SHALL have port energy_out  output  ENERGY_WIDTH  signed result, registered.
REQ-016 SHALL have port chunk_idx  output  $clog2(NUM_CHUNKS)  index of next chunk expected (column base = chunk_idx*J_COLS_PER_CLK).

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE on last chunk or abort, DONE->IDLE unconditionally after one cycle.
REQ-018 SHALL on accepted start latch sigma and energy_prev, clear accumulator and chunk_idx to 0, enter RUN next cycle.
REQ-019 SHALL drive j_ready=1 only in RUN; a chunk is accepted when j_valid && j_ready; no chunk accepted otherwise.
REQ-020 SHALL for accepted chunk add partial = sum over c of s(chunk_idx*J_COLS_PER_CLK+c) * sum over k of s(k)*J[k][c], s()=+/-1, J sign-extended, all arithmetic signed at ENERGY_WIDTH without saturation.
REQ-021 SHALL increment chunk_idx per accepted chunk; after chunk NUM_CHUNKS-1 chunk_idx wraps to 0 and FSM enters DONE.
REQ-022 SHALL in DONE assert done=1 for exactly one cycle, load energy_out with final accumulator, set aborted accordingly; energy_out and aborted hold until the next DONE.
REQ-023 SHALL assert busy=1 in RUN and DONE, 0 in IDLE.
REQ-024 SHALL ignore start in RUN and DONE.
REQ-025 SHALL on clear in RUN or DONE return to IDLE next cycle, suppress done, leave energy_out/aborted unchanged; clear has priority over an accepted chunk that cycle; clear in IDLE has no effect and start is ignored when clear=1.
REQ-026 SHALL allow arbitrary j_valid gaps; result independent of stall pattern; minimum latency start->done is NUM_CHUNKS+2 cycles with j_valid held high.

Reset
REQ-027 SHALL on rst=1 enter IDLE, clear accumulator, chunk_idx, energy_out, done, aborted, busy, j_ready to 0; rst overrides start and clear.
REQ-028 SHALL on rst mid-RUN discard the computation with no done pulse.

Configuration
REQ-029 SHALL support macro ISING_EARLY_ABORT_EN: when defined, after an accepted non-final chunk if updated accumulator >= latched energy_prev (signed) enter DONE with aborted=1 and energy_out = that partial sum; when undefined, no comparison logic, all NUM_CHUNKS always consumed, aborted tied 0.

Verification (VECTOR_SIZE=8, J_ELEMENT_WIDTH=4, J_COLS_PER_CLK=2, NUM_CHUNKS=4)
REQ-030 SHALL cover: sigma=8'hFF, all J=+1, j_valid held high -> done 6 cycles after start, energy_out=64, aborted=0.
REQ-031 SHALL cover: sigma=8'hFF, all J=-1 (4'hF) -> energy_out=-64; sigma=8'h0F, all J=+1 -> energy_out=0.
REQ-032 SHALL cover: j_valid toggled every other cycle, sigma=8'hFF, J=+1 -> energy_out=64, exactly 4 accepts, chunk_idx 0,1,2,3,0.
REQ-033 SHALL cover: with ISING_EARLY_ABORT_EN, sigma=8'hFF, J=+1, energy_prev=10 -> abort after chunk 0, energy_out=16, aborted=1; without macro -> 64, aborted=0.
REQ-034 SHALL cover: clear after 2 accepts -> no done, energy_out keeps prior 64, busy=0 next cycle; following start completes normally.
REQ-035 SHALL cover: rst=1 mid-RUN and start during RUN -> all outputs 0 after rst, start in RUN has no effect on result.
